// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared FSM states and default levels for the serial pattern generator
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    localparam logic DEF_IDLE_LVL = 1'b0;
    localparam int   DEF_RUN_LEN  = 4;

endpackage

// File: rtl/run_len_monitor.sv
// rtl/run_len_monitor.sv - flags when the current w completes a run of RUN_LEN equal values
module run_len_monitor
    import seq_pkg::*;
#(
    parameter int   RUN_LEN  = DEF_RUN_LEN,
    parameter logic IDLE_LVL = DEF_IDLE_LVL
) (
    input  logic clke,
    input  logic rst,
    input  logic w,
    output logic z_exp
);

    localparam int CW = $clog2(RUN_LEN + 1);

    logic [CW-1:0] run_q;
    logic [CW-1:0] run_d;
    logic          prev_q;

    // run_d is the run length including the current w, so z_exp is same-cycle
    always_comb begin
        run_d = CW'(1);
        if (w == prev_q) begin
            if (run_q >= CW'(RUN_LEN)) begin
                run_d = CW'(RUN_LEN);
            end else begin
                run_d = run_q + CW'(1);
            end
        end
    end

    assign z_exp = (run_d == CW'(RUN_LEN));

    always_ff @(posedge clke or posedge rst) begin
        if (rst) begin
            run_q  <= '0;
            prev_q <= IDLE_LVL;
        end else begin
            run_q  <= run_d;
            prev_q <= w;
        end
    end

endmodule

// File: rtl/serial_pattern_generator.sv
// rtl/serial_pattern_generator.sv - MSB-first serialiser with load handshake; SEQGEN_EXPECT_EN adds z_exp
module serial_pattern_generator
    import seq_pkg::*;
#(
    parameter int   WIDTH    = 16,
    parameter int   LEN_W    = 5,
`ifdef SEQGEN_EXPECT_EN
    parameter int   RUN_LEN  = DEF_RUN_LEN,
`endif
    parameter logic IDLE_LVL = DEF_IDLE_LVL
) (
    input  logic             clke,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             w,
    output logic             w_valid,
    output logic             done,
    output logic             z_exp
);

    seq_state_e       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [LEN_W-1:0] cnt_q;
    logic             w_q;
    logic             w_valid_q;
    logic             done_q;

    logic [LEN_W-1:0] len_d;
    logic [WIDTH-1:0] aligned_d;

    // Left-justify the pattern so its first bit sits at the shift register MSB
    always_comb begin
        len_d     = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
        aligned_d = load_data << (LEN_W'(WIDTH) - len_d);
    end

    assign load_ready = (state_q == ST_IDLE) & ~rst;
    assign w          = w_q;
    assign w_valid    = w_valid_q;
    assign done       = done_q;

    // cnt_q counts bits still to issue after the one currently on w
    always_ff @(posedge clke or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            w_q       <= IDLE_LVL;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (load_valid) begin
                        if (len_d == '0) begin
                            shreg_q <= '0;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            w_q       <= aligned_d[WIDTH-1];
                            w_valid_q <= 1'b1;
                            shreg_q   <= aligned_d << 1;
                            cnt_q     <= len_d - LEN_W'(1);
                            state_q   <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        w_q       <= IDLE_LVL;
                        w_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        w_q     <= shreg_q[WIDTH-1];
                        shreg_q <= shreg_q << 1;
                        cnt_q   <= cnt_q - LEN_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    w_q       <= IDLE_LVL;
                    w_valid_q <= 1'b0;
                    done_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SEQGEN_EXPECT_EN
    run_len_monitor #(
        .RUN_LEN  (RUN_LEN),
        .IDLE_LVL (IDLE_LVL)
    ) u_run_len_monitor (
        .clke  (clke),
        .rst   (rst),
        .w     (w_q),
        .z_exp (z_exp)
    );
`else
    assign z_exp = 1'b0;
`endif

endmodule

// File: tb/tb_serial_pattern_generator.sv
// tb/tb_serial_pattern_generator.sv - schedule-model bench for serial_pattern_generator
module tb_serial_pattern_generator;

    localparam int   WIDTH    = 16;
    localparam int   LEN_W    = 5;
    localparam logic IDLE_LVL = 1'b0;
    localparam int   RUN_LEN  = 4;

    logic             clke = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic             load_ready;
    logic [WIDTH-1:0] load_data = '0;
    logic [LEN_W-1:0] load_len = '0;
    logic             w;
    logic             w_valid;
    logic             done;
    logic             z_exp;

    int checks = 0;
    int errors = 0;

    serial_pattern_generator dut (
        .clke       (clke),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .w          (w),
        .w_valid    (w_valid),
        .done       (done),
        .z_exp      (z_exp)
    );

    always #5 clke = ~clke;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted pattern becomes a list of per-cycle line beats
    typedef struct {
        logic w;
        logic v;
        logic d;
    } beat_t;

    beat_t sched[$];
    beat_t cur = '{IDLE_LVL, 1'b0, 1'b0};
    logic  m_ready = 1'b1;
    logic  hist[$];

    always @(posedge clke or posedge rst) begin
        if (rst) begin
            sched.delete();
            cur     = '{IDLE_LVL, 1'b0, 1'b0};
            m_ready = 1'b1;
        end else begin
            if (m_ready && load_valid) begin
                int n;
                n = (int'(load_len) > WIDTH) ? WIDTH : int'(load_len);
                for (int i = n - 1; i >= 0; i--) sched.push_back('{load_data[i], 1'b1, 1'b0});
                sched.push_back('{IDLE_LVL, 1'b0, 1'b1});
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = '{IDLE_LVL, 1'b0, 1'b0};
            m_ready = (sched.size() == 0) && !cur.d;
        end
    end

    always @(negedge clke) begin
        logic exp_z;
        check("w", w, cur.w);
        check("w_valid", w_valid, cur.v);
        check("done", done, cur.d);
        check("load_ready", load_ready, !rst && m_ready);
        if (rst) begin
            hist.delete();
        end else begin
            hist.push_back(cur.w);
            if (hist.size() > RUN_LEN) void'(hist.pop_front());
        end
        exp_z = 1'b0;
`ifdef SEQGEN_EXPECT_EN
        if (!rst && hist.size() == RUN_LEN) begin
            exp_z = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) exp_z = 1'b0;
        end
`endif
        check("z_exp", z_exp, exp_z);
    end

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clke);
            if (load_ready) break;
        end
        check("wait_ready", load_ready, 1'b1);
    endtask

    task automatic run_pattern(input logic [15:0] data, input logic [4:0] len,
                               input logic [15:0] exp_bits, input int exp_n, input int exp_done);
        logic [15:0] bits;
        int n, done_c, ready_c;
        bits = '0; n = 0; done_c = -1; ready_c = -1;
        wait_ready();
        load_valid = 1'b1; load_data = data; load_len = len;
        @(posedge clke);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clke);
            if (c == 1) load_valid = 1'b0;
            if (w_valid) begin
                bits = {bits[14:0], w};
                n++;
            end
            if (done && done_c < 0) done_c = c;
            if (load_ready && ready_c < 0) begin
                ready_c = c;
                break;
            end
        end
        check("pat_bits", bits, exp_bits);
        check("pat_count", n, exp_n);
        check("pat_done_cycle", done_c, exp_done);
        check("pat_ready_cycle", ready_c, exp_done + 1);
    endtask

    initial begin
        repeat (2) @(negedge clke);
        check("reset_ready", load_ready, 1'b0);
        check("reset_w_valid", w_valid, 1'b0);
        @(posedge clke);
        #1 rst = 1'b0;

        run_pattern(16'h00F0, 5'd8, 16'h00F0, 8, 9);
        run_pattern(16'hFFFF, 5'd0, 16'h0000, 0, 1);
        run_pattern(16'hA5A5, 5'd20, 16'hA5A5, 16, 17);
        run_pattern(16'h0001, 5'd1, 16'h0001, 1, 2);

        begin : back_to_back
            logic [15:0] bits;
            int n, last_v, gap;
            logic drop;
            bits = '0; n = 0; last_v = 0; gap = -1; drop = 1'b0;
            wait_ready();
            load_valid = 1'b1; load_data = 16'h000B; load_len = 5'd4;
            @(posedge clke);
            for (int c = 1; c <= 30; c++) begin
                @(negedge clke);
                if (c == 1) begin
                    load_data = 16'h0006; load_len = 5'd3;
                end
                if (drop) load_valid = 1'b0;
                if (load_ready && load_valid) drop = 1'b1;
                if (w_valid) begin
                    bits = {bits[14:0], w};
                    n++;
                    if (n == 5) gap = c - last_v - 1;
                    last_v = c;
                end
            end
            load_valid = 1'b0;
            check("b2b_bits", bits, 16'h005E);
            check("b2b_count", n, 7);
            check("b2b_gap", gap, 2);
        end

        wait_ready();
        load_valid = 1'b1; load_data = 16'h00C3; load_len = 5'd8;
        @(posedge clke);
        @(negedge clke);
        load_valid = 1'b0;
        repeat (2) @(posedge clke);
        #1;
        check("mid_w_valid", w_valid, 1'b1);
        check("mid_bit3", w, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("rst_w", w, IDLE_LVL);
        check("rst_w_valid", w_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", load_ready, 1'b0);
        repeat (2) @(posedge clke);
        #1 rst = 1'b0;
        #1 check("post_rst_ready", load_ready, 1'b1);
        run_pattern(16'h003C, 5'd8, 16'h003C, 8, 9);

`ifdef SEQGEN_EXPECT_EN
        begin : expect_run
            logic [8:0] zs;
            zs = '0;
            @(posedge clke);
            #1 rst = 1'b1;
            @(posedge clke);
            #1 rst = 1'b0;
            repeat (10) @(negedge clke);
            check("z_idle", z_exp, 1'b1);
            load_valid = 1'b1; load_data = 16'h00F0; load_len = 5'd8;
            @(posedge clke);
            for (int c = 1; c <= 9; c++) begin
                @(negedge clke);
                if (c == 1) load_valid = 1'b0;
                zs = {zs[7:0], z_exp};
            end
            check("z_pattern", zs, 9'b000100011);
        end
`endif

        repeat (3) @(negedge clke);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
